seq_serializer: RTL and testbench

Parallel-to-serial front end for the sequence-detector path. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per Clk on `x`, which connects directly to the detector's serial input. Consecutive words stream with no gap, through a one-word holding register. When no data is pending, `x` is driven with a fixed idle level.

---
 rtl/seq_serializer_if.sv | 18 +
 rtl/seq_serializer.sv | 142 ++++++++++++++
 tb/tb_seq_serializer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_serializer_if
// Description : Word-input handshake bundle for seq_serializer. The source
//               drives din/din_valid; the serializer answers with din_ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;

    modport master (output din, output din_valid, input  din_ready);
    modport slave  (input  din, input  din_valid, output din_ready);
endinterface
`default_nettype wire

// File: rtl/seq_serializer.sv
`default_nettype none
// ============================================================================
// Module      : seq_serializer
// Description : Parallel-to-serial front end for the sequence detector.
//               Words arrive over a valid/ready handshake and leave one bit
//               per clock on x. A one-word holding register lets consecutive
//               words stream without a gap; x idles at IDLE_BIT otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic            Clk,
    input  logic            rst_n,
    input  logic            clr,
    seq_serializer_if.slave in_bus,
    output logic            x,
    output logic            x_valid,
    output logic            frame_start,
    output logic            busy
);

    localparam int                 CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   sr_q,        sr_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH-1:0]   hold_q,      hold_d;
    logic               hold_full_q, hold_full_d;
    logic               x_q;
    logic               x_valid_q;
    logic               frame_start_q;

    logic               w_accept;
    logic [WIDTH-1:0]   w_sr_shift;
    logic               w_first_bit_d;

    // The shift direction decides which end of sr is on the wire.
    if (MSB_FIRST) begin : g_msb_first
        assign w_sr_shift    = {sr_q[WIDTH-2:0], 1'b0};
        assign w_first_bit_d = sr_d[WIDTH-1];
    end else begin : g_lsb_first
        assign w_sr_shift    = {1'b0, sr_q[WIDTH-1:1]};
        assign w_first_bit_d = sr_d[0];
    end

    // Ready depends only on the holding register, so a hold load can never
    // collide with an incoming word.
    assign in_bus.din_ready = ~hold_full_q;
    assign w_accept         = in_bus.din_valid & ~hold_full_q;

    // Next-state: IDLE loads straight into sr; on the last bit the held word
    // wins, then a same-edge accept, otherwise the stream goes idle.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (clr) begin
            // Flush drops both words; any accept on this edge is lost.
            state_d     = S_IDLE;
            hold_full_d = 1'b0;
            cnt_d       = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        sr_d    = in_bus.din;
                        cnt_d   = '0;
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (cnt_q == CNT_LAST) begin
                        if (hold_full_q) begin
                            sr_d        = hold_q;
                            cnt_d       = '0;
                            hold_full_d = 1'b0;
                        end else if (w_accept) begin
                            sr_d  = in_bus.din;
                            cnt_d = '0;
                        end else begin
                            sr_d    = w_sr_shift;
                            cnt_d   = '0;
                            state_d = S_IDLE;
                        end
                    end else begin
                        sr_d  = w_sr_shift;
                        cnt_d = cnt_q + 1'b1;
                        if (w_accept) begin
                            hold_d      = in_bus.din;
                            hold_full_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered serial outputs; outputs are computed
    // from next-state so x shows a word's first bit right after its accept.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            sr_q          <= '0;
            cnt_q         <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            x_q           <= IDLE_BIT;
            x_valid_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            cnt_q         <= cnt_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            x_q           <= (state_d == S_SHIFT) ? w_first_bit_d : IDLE_BIT;
            x_valid_q     <= (state_d == S_SHIFT);
            frame_start_q <= (state_d == S_SHIFT) && (cnt_d == '0);
        end
    end

    assign x           = x_q;
    assign x_valid     = x_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q == S_SHIFT) | hold_full_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_serializer
// Description : Scoreboard bench for seq_serializer. Stimulus pushes the
//               hand-computed bit sequence of each accepted word; a monitor
//               pops and compares every cycle x_valid is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_serializer;

    localparam int WIDTH = 8;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic rst_n;
    logic clr_m, clr_l;
    logic x_m, xv_m, fs_m, busy_m;
    logic x_l, xv_l, fs_l, busy_l;

    seq_serializer_if #(.WIDTH(WIDTH)) bus_m ();
    seq_serializer_if #(.WIDTH(WIDTH)) bus_l ();

    seq_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .Clk(Clk), .rst_n(rst_n), .clr(clr_m), .in_bus(bus_m),
        .x(x_m), .x_valid(xv_m), .frame_start(fs_m), .busy(busy_m)
    );

    seq_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
        .Clk(Clk), .rst_n(rst_n), .clr(clr_l), .in_bus(bus_l),
        .x(x_l), .x_valid(xv_l), .frame_start(fs_l), .busy(busy_l)
    );

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_m[$];      // {frame_start, x}
    logic [1:0] exp_l[$];
    logic [1:0] pop_m, pop_l;
    int run_len = 0;
    int last_run = 0;
    int ready_low_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // seq[7] is the first bit expected on the wire.
    task automatic push_seq(input bit lsb, input logic [7:0] seq);
        logic [1:0] e;
        for (int i = 7; i >= 0; i--) begin
            e = {1'(i == 7), seq[i]};
            if (lsb) exp_l.push_back(e);
            else     exp_m.push_back(e);
        end
    endtask

    task automatic send(input bit lsb, input logic [7:0] w, input logic [7:0] seq, input bit keep_valid);
        bit acc;
        bit r;
        acc = 1'b0;
        if (lsb) begin bus_l.din = w; bus_l.din_valid = 1'b1; end
        else     begin bus_m.din = w; bus_m.din_valid = 1'b1; end
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge Clk);
            r = lsb ? bus_l.din_ready : bus_m.din_ready;
            @(posedge Clk);
            if (r) acc = 1'b1;
        end
        if (acc) push_seq(lsb, seq);
        #1;
        if (!keep_valid) begin
            if (lsb) bus_l.din_valid = 1'b0;
            else     bus_m.din_valid = 1'b0;
        end
        chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    // Monitor: compare every data bit against the scoreboard, idle level otherwise.
    always @(negedge Clk) begin
        if (xv_m) begin
            if (exp_m.size() == 0) chk("m_unexpected_bit", 32'd1, 32'd0);
            else begin
                pop_m = exp_m.pop_front();
                chk("m_x", 32'(x_m), 32'(pop_m[0]));
                chk("m_frame_start", 32'(fs_m), 32'(pop_m[1]));
            end
            run_len++;
        end else begin
            chk("m_idle_x", 32'(x_m), 32'd0);
            chk("m_idle_fs", 32'(fs_m), 32'd0);
            if (run_len > 0) begin
                last_run = run_len;
                run_len  = 0;
            end
        end
        if (!bus_m.din_ready) ready_low_cnt++;

        if (xv_l) begin
            if (exp_l.size() == 0) chk("l_unexpected_bit", 32'd1, 32'd0);
            else begin
                pop_l = exp_l.pop_front();
                chk("l_x", 32'(x_l), 32'(pop_l[0]));
                chk("l_frame_start", 32'(fs_l), 32'(pop_l[1]));
            end
        end else begin
            chk("l_idle_x", 32'(x_l), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clr_m = 1'b0; clr_l = 1'b0;
        bus_m.din = '0; bus_m.din_valid = 1'b0;
        bus_l.din = '0; bus_l.din_valid = 1'b0;
        #1;
        chk("rst_din_ready", 32'(bus_m.din_ready), 32'd1);
        chk("rst_busy", 32'(busy_m), 32'd0);
        chk("rst_x", 32'(x_m), 32'd0);
        chk("rst_x_valid", 32'(xv_m), 32'd0);
        chk("rst_frame_start", 32'(fs_m), 32'd0);
        repeat (2) @(posedge Clk);
        #1 rst_n = 1'b1;
        @(posedge Clk); #1;

        // Single word A5, MSB first.
        send(1'b0, 8'hA5, 8'b1010_0101, 1'b0);
        chk("single_first_valid", 32'(xv_m), 32'd1);
        chk("single_first_fs", 32'(fs_m), 32'd1);
        repeat (10) @(posedge Clk); #1;
        chk("single_run_len", 32'(last_run), 32'd8);
        chk("single_drained", 32'(exp_m.size()), 32'd0);
        chk("single_busy_end", 32'(busy_m), 32'd0);

        // Streaming with din_valid held high.
        ready_low_cnt = 0;
        send(1'b0, 8'h92, 8'b1001_0010, 1'b1);
        send(1'b0, 8'h49, 8'b0100_1001, 1'b1);
        send(1'b0, 8'hFF, 8'b1111_1111, 1'b0);
        repeat (30) @(posedge Clk); #1;
        chk("stream_run_len", 32'(last_run), 32'd24);
        chk("stream_ready_low", 32'(ready_low_cnt), 32'd14);
        chk("stream_drained", 32'(exp_m.size()), 32'd0);

        // Word offered exactly on the last-bit edge: bypass, hold untouched.
        ready_low_cnt = 0;
        send(1'b0, 8'hC3, 8'b1100_0011, 1'b0);
        repeat (7) @(posedge Clk); #1;
        send(1'b0, 8'h5A, 8'b0101_1010, 1'b0);
        repeat (20) @(posedge Clk); #1;
        chk("bypass_run_len", 32'(last_run), 32'd16);
        chk("bypass_hold_never_full", 32'(ready_low_cnt), 32'd0);
        chk("bypass_drained", 32'(exp_m.size()), 32'd0);

        // LSB first: 01 goes out as 1 followed by seven zeros.
        send(1'b1, 8'h01, 8'b1000_0000, 1'b0);
        chk("lsb_first_fs", 32'(fs_l), 32'd1);
        repeat (10) @(posedge Clk); #1;
        chk("lsb_drained", 32'(exp_l.size()), 32'd0);
        chk("lsb_busy_end", 32'(busy_l), 32'd0);

        // Asynchronous reset at bit 3 of A5 with the holding register full.
        send(1'b0, 8'hA5, 8'b1010_0101, 1'b0);
        send(1'b0, 8'h3C, 8'b0011_1100, 1'b0);
        chk("rstmid_hold_full", 32'(bus_m.din_ready), 32'd0);
        repeat (2) @(posedge Clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_x", 32'(x_m), 32'd0);
        chk("rstmid_x_valid", 32'(xv_m), 32'd0);
        chk("rstmid_busy", 32'(busy_m), 32'd0);
        chk("rstmid_fs", 32'(fs_m), 32'd0);
        exp_m.delete();
        repeat (2) @(posedge Clk); #1;
        rst_n = 1'b1;
        chk("rstmid_ready_after", 32'(bus_m.din_ready), 32'd1);
        repeat (20) @(posedge Clk); #1;
        chk("rstmid_busy_after", 32'(busy_m), 32'd0);

        // Synchronous flush while streaming with the holding register full.
        send(1'b0, 8'h92, 8'b1001_0010, 1'b0);
        send(1'b0, 8'h49, 8'b0100_1001, 1'b0);
        repeat (2) @(posedge Clk); #1;
        clr_m = 1'b1;
        @(posedge Clk); #1;
        clr_m = 1'b0;
        exp_m.delete();
        chk("clr_x_valid", 32'(xv_m), 32'd0);
        chk("clr_hold_cleared", 32'(bus_m.din_ready), 32'd1);
        chk("clr_busy", 32'(busy_m), 32'd0);
        // An accept coinciding with clr is discarded.
        bus_m.din = 8'hFF; bus_m.din_valid = 1'b1; clr_m = 1'b1;
        @(posedge Clk); #1;
        bus_m.din_valid = 1'b0; clr_m = 1'b0;
        chk("clr_drop_accept_valid", 32'(xv_m), 32'd0);
        chk("clr_drop_accept_busy", 32'(busy_m), 32'd0);
        repeat (2) @(posedge Clk); #1;
        send(1'b0, 8'hE7, 8'b1110_0111, 1'b0);
        chk("clr_new_latency_valid", 32'(xv_m), 32'd1);
        chk("clr_new_fs", 32'(fs_m), 32'd1);
        chk("clr_new_x", 32'(x_m), 32'd1);
        repeat (12) @(posedge Clk); #1;
        chk("clr_new_run_len", 32'(last_run), 32'd8);
        chk("clr_new_drained", 32'(exp_m.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
